// File: rtl/serial_accumulator.sv
// serial_accumulator: run-once accumulator for the adders-lab datapath.
// One operation (load/add/sub/clear) per Run rising edge seen in IDLE.
// Add/sub ripple CHUNK bits per cycle over N cycles, then commit to Acc.
module serial_accumulator #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned ACC_W = 17,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [1:0]       Mode,
    input  logic [IN_W-1:0]  Din,
    output logic [ACC_W-1:0] Acc,
    output logic             Busy,
    output logic             Done,
    output logic             C
);

    localparam int unsigned N      = (ACC_W + CHUNK - 1) / CHUNK;
    localparam int unsigned LAST_W = ACC_W - (N - 1) * CHUNK;
    localparam int unsigned K_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LO_W   = $clog2(ACC_W + 1);
    localparam int unsigned SUM_W  = CHUNK + 1;

    localparam logic [K_W-1:0]   K_LAST     = K_W'(N - 1);
    localparam logic [CHUNK-1:0] CHUNK_ONES = '1;

    localparam logic [1:0] M_LOAD  = 2'b00;
    localparam logic [1:0] M_ADD   = 2'b01;
    localparam logic [1:0] M_SUB   = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run_q;
    logic [ACC_W-1:0]   r_acc;
    logic               r_c;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_b;
    logic               r_cy;
    logic               r_sub;
    logic [K_W-1:0]     r_k;
    logic [ACC_W-1:0]   r_r;

    logic               w_trigger;
    logic               w_last;
    logic [ACC_W-1:0]   w_operand;
    logic [LO_W-1:0]    w_lo;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [SUM_W-1:0]   w_sum;
    logic               w_cy_out;
    logic [ACC_W-1:0]   w_r_nxt;
    logic               w_c_commit;
    logic [ACC_W-1:0]   w_acc_commit;

    assign w_trigger = Run && !r_run_q && (r_state == S_IDLE);
    assign w_last    = (r_k == K_LAST);
    assign w_operand = ACC_W'(Din);
    assign w_lo      = LO_W'(r_k) * LO_W'(CHUNK);
    assign w_a_chunk = CHUNK'(r_acc >> w_lo);
    assign w_b_chunk = CHUNK'(r_b >> w_lo);
    assign w_sum     = SUM_W'(w_a_chunk) + SUM_W'(w_b_chunk) + SUM_W'(r_cy);
    // A partial top chunk carries out of bit ACC_W-1, not out of bit CHUNK-1.
    assign w_cy_out  = w_last ? w_sum[LAST_W] : w_sum[CHUNK];
    assign w_c_commit = r_sub ? ~w_cy_out : w_cy_out;

    // Merge the current chunk into the partial result and form the committed value.
    always_comb begin
        w_r_nxt      = (r_r & ~(ACC_W'(CHUNK_ONES) << w_lo))
                     | (ACC_W'(w_sum[CHUNK-1:0]) << w_lo);
        w_acc_commit = w_r_nxt;
        if ((SAT != 0) && w_c_commit) begin
            w_acc_commit = r_sub ? '0 : '1;
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    if ((Mode == M_ADD) || (Mode == M_SUB)) begin
                        w_state_nxt = S_CALC;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, edge detector and registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_run_q <= 1'b1;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_b     <= '0;
            r_cy    <= 1'b0;
            r_sub   <= 1'b0;
            r_k     <= '0;
            r_r     <= '0;
        end else begin
            r_run_q <= Run;
            r_busy  <= (w_state_nxt == S_CALC);
            r_done  <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_k <= '0;
                        case (Mode)
                            M_LOAD: begin
                                r_acc <= w_operand;
                                r_c   <= 1'b0;
                            end
                            M_ADD: begin
                                r_b   <= w_operand;
                                r_cy  <= 1'b0;
                                r_sub <= 1'b0;
                            end
                            M_SUB: begin
                                r_b   <= ~w_operand;
                                r_cy  <= 1'b1;
                                r_sub <= 1'b1;
                            end
                            M_CLEAR: begin
                                r_acc <= '0;
                                r_c   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    r_r  <= w_r_nxt;
                    r_cy <= w_cy_out;
                    if (w_last) begin
                        r_acc <= w_acc_commit;
                        r_c   <= w_c_commit;
                        r_k   <= '0;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Acc  = r_acc;
    assign C    = r_c;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: doc/serial_accumulator.md
# serial_accumulator

Parametrised run-once accumulator for the adders-lab datapath, generalising the fixed 17-bit switch accumulator. Each Run press triggers exactly one operation (load, add, subtract, clear) on a zero-extended switch operand. Add and subtract execute as a multi-cycle chunked ripple of CHUNK bits per cycle, with a Busy/Done handshake and optional saturation. Sits between the switch/button inputs and the hex/LED display drivers.

## Interface
- IN_W, default 10: operand width (switches).
- ACC_W, default 17: accumulator width; must satisfy ACC_W >= IN_W.
- CHUNK, default 4: bits summed per cycle, 1..ACC_W; N = ceil(ACC_W/CHUNK) calc cycles; the last chunk may be partial.
- SAT, default 0: 0 = wrap-around; 1 = saturate (add clamps to all-ones, subtract clamps to 0).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  level, active-high; the rising edge requests one operation.
- Mode  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR; sampled on the trigger edge.
- Din  in  IN_W  operand, zero-extended to ACC_W; sampled on the trigger edge.
- Acc  out  ACC_W  accumulator value.
- Busy  out  1  high while in CALC.
- Done  out  1  one-cycle completion pulse.
- C  out  1  ADD: carry-out of bit ACC_W-1. SUB: borrow. LOAD/CLEAR: 0. Holds until the next commit.

## Operation
- Trigger: Run_q registers Run every cycle in every state. A trigger occurs when Run=1, Run_q=0 and state = IDLE.
  - Rising edges outside IDLE are dropped, not queued.
  - Holding Run high never retriggers; Run must be released first.
- State machine, states IDLE, CALC, DONE:
  - IDLE, trigger with LOAD: Acc <= ext(Din), C <= 0; go to DONE.
  - IDLE, trigger with CLEAR: Acc <= 0, C <= 0; go to DONE.
  - IDLE, trigger with ADD or SUB: latch operand B, where B = ext(Din) for ADD and ~ext(Din) for SUB.
    - Initialise carry cy = 0 for ADD, 1 for SUB; chunk index k = 0; go to CALC.
  - CALC: compute R[chunk k] = Acc[chunk k] + B[chunk k] + cy; update cy; k++.
    - After chunk N-1, commit and go to DONE.
  - DONE: Done = 1 for this single cycle; go to IDLE.
- Commit rules:
  - ADD: C = cy.
  - SUB: C = ~cy (borrow).
  - SAT=0: Acc <= R.
  - SAT=1: if C, Acc <= all-ones for ADD, 0 for SUB; otherwise Acc <= R.
- Acc is not modified during CALC; partial sums live only in R. Din and Mode changes after the trigger have no effect.
- Arithmetic is unsigned modulo 2^ACC_W. Bits above IN_W in the operand are 0.

## Timing
- Reset (asynchronous, takes effect immediately, independent of Clk):
  - Acc=0, C=0, Busy=0, Done=0, state IDLE, k=0.
  - Run_q=1, so a Run held high through reset release does not trigger.
- Cycle numbering: trigger sampled at edge t.
- LOAD/CLEAR: Acc updates at edge t; Done=1 in cycle (t, t+1]; IDLE at t+1. The next trigger can be sampled at edge t+2.
- ADD/SUB:
  - Busy=1 from edge t to edge t+N.
  - Acc and C update at edge t+N.
  - Done=1 in cycle (t+N, t+N+1].
  - Busy and Done are never high together.
- Reset asserted mid-CALC aborts the operation: no commit, and no Done pulse.
- Throughput: one ADD/SUB per N+2 cycles minimum, limited further by Run release.

## Test plan
- Reset, then LOAD with Din=0x3FF -> Acc=0x003FF, C=0; Done pulses exactly 1 cycle after the trigger edge; Busy never high.
- Defaults: Acc=0x1FFFF, ADD Din=0x001 -> Busy high for exactly 5 cycles, then Acc=0x00000, C=1, single Done pulse. Same stimulus with SAT=1 -> Acc=0x1FFFF, C=1.
- Acc=0x00005, SUB Din=0x007 -> Acc=0x1FFFE, C=1; with SAT=1 -> Acc=0x00000, C=1. Acc=0x00009, SUB 0x004 -> Acc=0x00005, C=0.
- Run held high for 20 cycles with ADD Din=0x010 -> exactly one add. Extra Run pulses and Din/Mode changes during Busy -> ignored; result uses the trigger-edge Din.
- Reset asserted in the 3rd CALC cycle -> Acc=0 and Busy=0 immediately with no Done pulse. Run held high across reset release -> no operation until Run falls and rises again.
- Parameter sweep ACC_W=17, CHUNK=5 (N=4): Acc=0x0FFFF, ADD 0x3FF -> Acc=0x103FE, C=0, Busy for 4 cycles. CHUNK=17 (N=1) -> same result, Busy for 1 cycle.
